// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the adder compare stage
package addsub_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 5;

  // funct3 encoding of the compare operations
  typedef enum logic [2:0] {
    CMP_EQ   = 3'b000,
    CMP_NE   = 3'b001,
    CMP_SLT  = 3'b010,
    CMP_SLTU = 3'b011,
    CMP_LT   = 3'b100,
    CMP_GE   = 3'b101,
    CMP_LTU  = 3'b110,
    CMP_GEU  = 3'b111
  } cmp_op_e;

  typedef struct packed {
    logic                  taken;
    logic [DATA_W_DEF-1:0] value;
    logic [TAG_W_DEF-1:0]  tag;
  } cmp_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;

  function automatic logic is_set_op(cmp_op_e op);
    return (op == CMP_SLT) || (op == CMP_SLTU);
  endfunction

endpackage

// File: rtl/addsub_compare_stage_if.sv
// rtl/addsub_compare_stage_if.sv - upstream/downstream handshake bundle of the compare stage
interface addsub_compare_stage_if
  import addsub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_carry;
  logic              in_overflow;
  cmp_op_e           in_op;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic              out_taken;
  logic [DATA_W-1:0] out_value;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, in_result, in_carry, in_overflow, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_taken, out_value, out_tag
  );

  modport master (
    output in_valid, in_result, in_carry, in_overflow, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_taken, out_value, out_tag
  );
endinterface

// File: rtl/addsub_compare_stage_cmp_eval.sv
// rtl/addsub_compare_stage_cmp_eval.sv - combinational compare decode from adder flags (A-B)
module cmp_eval
  import addsub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] result_i,
  input  logic              carry_i,
  input  logic              overflow_i,
  input  cmp_op_e           op_i,
  output logic              taken_o,
  output logic [DATA_W-1:0] value_o
);
  logic zero;
  logic lt_s;
  logic lt_u;

  // carry out of A + ~B + 1 is the "no borrow" flag, so unsigned less-than is its inverse
  assign zero = (result_i == '0);
  assign lt_s = result_i[DATA_W-1] ^ overflow_i;
  assign lt_u = ~carry_i;

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      CMP_EQ:   taken_o = zero;
      CMP_NE:   taken_o = ~zero;
      CMP_SLT:  taken_o = lt_s;
      CMP_SLTU: taken_o = lt_u;
      CMP_LT:   taken_o = lt_s;
      CMP_GE:   taken_o = ~lt_s;
      CMP_LTU:  taken_o = lt_u;
      CMP_GEU:  taken_o = ~lt_u;
      default:  taken_o = 1'b0;
    endcase
  end

  assign value_o = is_set_op(op_i) ? {{(DATA_W-1){1'b0}}, taken_o} : result_i;

endmodule

// File: rtl/addsub_compare_stage.sv
// rtl/addsub_compare_stage.sv - registered compare stage with a 2-entry skid buffer
module addsub_compare_stage
  import addsub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input logic                   clock,
  input logic                   reset_n,
  input logic                   flush,
  addsub_compare_stage_if.slave bus
);
  typedef struct packed {
    logic              taken;
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  skid_state_e       state_q, state_d;
  entry_t            main_q, skid_q, new_entry;
  logic              load_main_new, load_main_skid, load_skid;
  logic              in_fire, out_fire;
  logic              eval_taken;
  logic [DATA_W-1:0] eval_value;

  cmp_eval #(.DATA_W(DATA_W)) u_cmp_eval (
    .result_i   (bus.in_result),
    .carry_i    (bus.in_carry),
    .overflow_i (bus.in_overflow),
    .op_i       (bus.in_op),
    .taken_o    (eval_taken),
    .value_o    (eval_value)
  );

  assign new_entry = '{taken: eval_taken, value: eval_value, tag: bus.in_tag};

  // ready depends only on state, so it never combinationally follows out_ready
  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_taken = main_q.taken;
  assign bus.out_value = main_q.value;
  assign bus.out_tag   = main_q.tag;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d       = ST_ONE;
          load_main_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main_new = 1'b1;
        end else if (in_fire) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_new) begin
        main_q <= new_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
    end
  end

  // skid contents are only observed after a load, so they carry no reset
  always_ff @(posedge clock) begin
    if (load_skid) begin
      skid_q <= new_entry;
    end
  end

endmodule
